// File: rtl/delay_pkg.sv
// Shared definitions for the per-rail variable sample delay of the delay NoC block.
package delay_pkg;

  localparam int DLY_WIDTH        = 16;
  localparam int DLY_MAX_LEN_LOG2 = 16;

  typedef enum logic [1:0] {
    ST_PASS   = 2'd0,
    ST_INSERT = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output holding register; 1-cycle latency, loads when empty or draining.
// Contents stay stable while the downstream stalls; a load cycle with no request empties it.
module axis_out_reg
  import delay_pkg::*;
#(
  parameter int WIDTH = DLY_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_ld_vld,
  input  logic [WIDTH-1:0] i_ld_dat,
  input  logic             i_ld_last,
  output logic             o_load_ok,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             i_tready
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;
  logic             r_last;

  assign o_load_ok = !r_vld || i_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_last <= 1'b0;
    end else if (o_load_ok) begin
      r_vld <= i_ld_vld;
      if (i_ld_vld) begin
        r_dat  <= i_ld_dat;
        r_last <= i_ld_last;
      end
    end
  end

  assign o_tdata  = r_dat;
  assign o_tlast  = r_last;
  assign o_tvalid = r_vld;

endmodule

// File: rtl/axis_var_delay.sv
// AXI-Stream sample delay: inserts zeros / drops samples until cur_delay reaches len, optional re-framing.
// 1-cycle latency, 1 sample/cycle; DROP keeps draining the input even while the output stalls.
module axis_var_delay
  import delay_pkg::*;
#(
  parameter int WIDTH        = DLY_WIDTH,
  parameter int MAX_LEN_LOG2 = DLY_MAX_LEN_LOG2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [WIDTH-1:0]        o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  input  logic [MAX_LEN_LOG2-1:0] len,
  input  logic [15:0]             max_spp,
  output logic [MAX_LEN_LOG2-1:0] cur_delay,
  output logic                    busy
);

  state_t                  r_state, w_state_nxt;
  logic [MAX_LEN_LOG2-1:0] r_len, r_cur, w_cur_nxt;
  logic [15:0]             r_spp_cnt, w_spp_cnt_nxt, r_spp_lat, w_spp_lat_nxt, w_spp_eff;
  logic                    r_pend_last, w_pend_nxt, r_busy;
  logic                    w_load_ok, w_ld_vld, w_ld_last, w_pass_emit, w_i_tready;
  logic [WIDTH-1:0]        w_ld_dat;

  axis_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_ld_vld  (w_ld_vld),
    .i_ld_dat  (w_ld_dat),
    .i_ld_last (w_ld_last),
    .o_load_ok (w_load_ok),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .i_tready  (o_tready)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_PASS;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_PASS);
    end
  end

  always_comb begin
    w_i_tready    = 1'b0;
    w_ld_vld      = 1'b0;
    w_ld_dat      = '0;
    w_ld_last     = 1'b0;
    w_pass_emit   = 1'b0;
    w_cur_nxt     = r_cur;
    w_pend_nxt    = r_pend_last;
    w_spp_cnt_nxt = r_spp_cnt;
    w_spp_lat_nxt = r_spp_lat;
    w_spp_eff     = (r_spp_cnt == 16'd0) ? max_spp : r_spp_lat;

    case (r_state)
      ST_PASS: begin
        w_i_tready = w_load_ok;
        if (i_tvalid && w_load_ok) begin
          w_ld_vld    = 1'b1;
          w_ld_dat    = i_tdata;
          w_pass_emit = 1'b1;
        end
      end
      ST_INSERT: begin
        // r_len guard keeps cur_delay from ever stepping past the target
        if (w_load_ok && (r_cur < r_len)) begin
          w_ld_vld  = 1'b1;
          w_cur_nxt = r_cur + 1'b1;
        end
      end
      ST_DROP: begin
        w_i_tready = 1'b1;
        if (i_tvalid) begin
          w_cur_nxt = r_cur - 1'b1;
          if (i_tlast) w_pend_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    if (w_pass_emit) w_pend_nxt = 1'b0;

    if (w_ld_vld) begin
      if (w_spp_eff == 16'd0) begin
        w_ld_last     = w_pass_emit && (i_tlast || r_pend_last);
        w_spp_cnt_nxt = 16'd0;
      end else begin
        w_spp_lat_nxt = w_spp_eff;
        w_ld_last     = (r_spp_cnt == w_spp_eff - 16'd1);
        w_spp_cnt_nxt = w_ld_last ? 16'd0 : r_spp_cnt + 16'd1;
      end
    end

    // Compare against the value r_len takes at this edge so the state always matches len_r vs cur_delay
    if (len > w_cur_nxt)      w_state_nxt = ST_INSERT;
    else if (len < w_cur_nxt) w_state_nxt = ST_DROP;
    else                      w_state_nxt = ST_PASS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len       <= '0;
      r_cur       <= '0;
      r_spp_cnt   <= 16'd0;
      r_spp_lat   <= 16'd0;
      r_pend_last <= 1'b0;
    end else begin
      r_len       <= len;
      r_cur       <= w_cur_nxt;
      r_spp_cnt   <= w_spp_cnt_nxt;
      r_spp_lat   <= w_spp_lat_nxt;
      r_pend_last <= w_pend_nxt;
    end
  end

  assign i_tready  = w_i_tready;
  assign cur_delay = r_cur;
  assign busy      = r_busy;

endmodule

// File: doc/axis_var_delay.md
Name: axis_var_delay

Overview:
- Single-channel AXI-Stream sample delay for the per-rail paths of the delay NoC block; sits between the I/Q split FIFO and the per-rail re-alignment buffers.
- Retards the stream by inserting zero samples and advances it by dropping samples, until the applied delay equals the programmed length.
- Optionally re-frames output packets at a fixed samples-per-packet.
- Full-throughput, one sample per cycle, with a registered output stage.

Parameters:
WIDTH, 16, sample width in bits
MAX_LEN_LOG2, 16, width of the delay length and of the applied-delay counter

Ports:
clk  in  1  clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
i_tdata  in  WIDTH  input sample
i_tlast  in  1  input end-of-packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  WIDTH  output sample
o_tlast  out  1  output end-of-packet
o_tvalid  out  1  output valid
o_tready  in  1  output ready
len  in  MAX_LEN_LOG2  requested delay in samples, unsigned, may change at any time
max_spp  in  16  output packet length in samples; 0 means pass input tlast through
cur_delay  out  MAX_LEN_LOG2  currently applied delay, for readback
busy  out  1  high when state is not PASS

Behaviour:
- Reset (reset_n low, asynchronous): o_tvalid=0, o_tdata=0, o_tlast=0, cur_delay=0, busy=0, state=PASS, len_r=0, spp_cnt=0, pend_last=0.
  - Reset mid-operation discards the output register contents and any pending insert or drop.
- len is registered into len_r each cycle. All decisions use len_r, so a len change takes effect 1 cycle later.
- Output register:
  - It loads when load_ok = !o_tvalid | o_tready.
  - o_tvalid and its data are held stable until o_tready.
  - Latency from input to output is 1 cycle; throughput is 1 sample/cycle.
- State is re-evaluated every cycle after any transfer:
  - len_r > cur_delay: INSERT.
  - len_r < cur_delay: DROP.
  - Otherwise: PASS.
- PASS:
  - i_tready = load_ok.
  - On an input handshake, o_tdata = i_tdata, o_tvalid = 1.
- INSERT:
  - i_tready = 0.
  - When load_ok, emit one zero sample, o_tvalid = 1, and cur_delay += 1.
  - Inserted samples do not depend on i_tvalid.
- DROP:
  - i_tready = 1, independent of the output side.
  - Each input handshake consumes the sample without emitting it, and cur_delay -= 1.
  - If a dropped sample has tlast=1, set pend_last.
- Saturation: cur_delay never wraps. It moves by at most 1 per cycle and only toward len_r.
- Direction reversal: if len_r reverses direction mid-INSERT or mid-DROP, the state switches on the next evaluation with no extra bubble.
- tlast when max_spp == 0:
  - Emitted passthrough sample: o_tlast = i_tlast | pend_last; pend_last clears on that emission.
  - Inserted zero samples: o_tlast = 0.
- tlast when max_spp != 0:
  - Input tlast and pend_last are ignored.
  - spp_cnt counts every emitted sample, passed or inserted.
  - o_tlast = 1 when spp_cnt == max_spp-1, after which spp_cnt returns to 0.
  - A change to max_spp takes effect at the next packet start (spp_cnt == 0).
- Simultaneous events:
  - DROP combined with output backpressure: input continues to drain.
  - PASS combined with output backpressure: i_tready = 0 and no sample is lost.
- busy = (state != PASS). It is registered, updating with state.

Decomposition:
- Shared package delay_pkg holds:
  - state encodings ST_PASS=2'd0, ST_INSERT=2'd1, ST_DROP=2'd2;
  - the default MAX_LEN_LOG2 and WIDTH values used by the NoC delay block.
- One natural sub-module, axis_out_reg. It is the output holding register with load_ok logic, reused by INSERT and PASS.
- The control FSM, counters and tlast logic stay in axis_var_delay.

Test Plan:
- Passthrough: len=0, max_spp=0, ramp 1..10 with tlast on 10, o_tready=1.
  - Output is 1..10 with tlast on 10, 1-cycle latency.
  - busy stays 0 and i_tready stays 1 throughout.
- Retard: len stepped 0->3 during a continuous ramp.
  - Exactly three zero samples are inserted between consecutive ramp values; i_tready is low for 3 cycles.
  - cur_delay goes 1,2,3; busy falls afterwards.
- Advance: from len=3, set len=1.
  - The next two input samples are consumed and absent from the output; cur_delay=1.
  - If the second dropped sample had tlast, the next emitted sample carries tlast.
- Backpressure: o_tready toggles 1010 with random i_tvalid, len 0->2->0.
  - The output equals a reference model; no duplicated or lost samples.
  - o_tdata and o_tvalid are stable while stalled.
- Re-framing: max_spp=4, len 0->2.
  - tlast appears on every 4th output sample, counting inserted zeros.
- Reset mid-INSERT: with len=8, assert reset_n low at cur_delay=4.
  - o_tvalid=0 and cur_delay=0 asynchronously.
  - After release with len still 8, insertion restarts from 0.
